// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, one-hot command layout,
// immediate formats and the ID/EX pipeline record.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam int CMD_W       = 12;
  localparam int CMD_LUI     = 11;
  localparam int CMD_AUIPC   = 10;
  localparam int CMD_JAL     = 9;
  localparam int CMD_JALR    = 8;
  localparam int CMD_BR      = 7;
  localparam int CMD_LD      = 6;
  localparam int CMD_ST      = 5;
  localparam int CMD_ALUI    = 4;
  localparam int CMD_ALU     = 3;
  localparam int CMD_ECALL   = 2;
  localparam int CMD_MRET    = 1;
  localparam int CMD_ILLEGAL = 0;

  // Classes that produce a register result: lui, auipc, jal, jalr, ld, alui, alu.
  localparam logic [CMD_W-1:0] WBK_MASK = 12'hF58;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    imm_sel_e         imm_sel;
    logic             rs1_use;
    logic             rs2_use;
  } dec_t;

  typedef struct packed {
    logic [29:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      rs1_data;
    logic [31:0]      rs2_data;
    logic [31:0]      imm;
    logic [4:0]       rd_adr;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [CMD_W-1:0] cmd;
    logic             wbk_en;
  } idex_t;

  function automatic logic [31:0] gen_imm(input imm_sel_e sel, input logic [31:0] inst);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  function automatic dec_t decode_class(input logic [31:0] inst);
    dec_t d;
    d.cmd     = '0;
    d.imm_sel = IMM_NONE;
    d.rs1_use = 1'b0;
    d.rs2_use = 1'b0;
    case (inst[6:0])
      OP_LUI:   begin d.cmd[CMD_LUI] = 1'b1;   d.imm_sel = IMM_U; end
      OP_AUIPC: begin d.cmd[CMD_AUIPC] = 1'b1; d.imm_sel = IMM_U; end
      OP_JAL:   begin d.cmd[CMD_JAL] = 1'b1;   d.imm_sel = IMM_J; end
      OP_JALR:  begin d.cmd[CMD_JALR] = 1'b1;  d.imm_sel = IMM_I; d.rs1_use = 1'b1; end
      OP_BR: begin
        d.cmd[CMD_BR] = 1'b1;
        d.imm_sel     = IMM_B;
        d.rs1_use     = 1'b1;
        d.rs2_use     = 1'b1;
      end
      OP_LD:    begin d.cmd[CMD_LD] = 1'b1;    d.imm_sel = IMM_I; d.rs1_use = 1'b1; end
      OP_ST: begin
        d.cmd[CMD_ST] = 1'b1;
        d.imm_sel     = IMM_S;
        d.rs1_use     = 1'b1;
        d.rs2_use     = 1'b1;
      end
      OP_ALUI:  begin d.cmd[CMD_ALUI] = 1'b1;  d.imm_sel = IMM_I; d.rs1_use = 1'b1; end
      OP_ALU: begin
        d.cmd[CMD_ALU] = 1'b1;
        d.rs1_use      = 1'b1;
        d.rs2_use      = 1'b1;
      end
      // Only the exact ecall/mret encodings are accepted from SYSTEM.
      OP_SYS: begin
        if (inst == INST_ECALL) begin
          d.cmd[CMD_ECALL] = 1'b1;
        end else if (inst == INST_MRET) begin
          d.cmd[CMD_MRET] = 1'b1;
        end else begin
          d.cmd[CMD_ILLEGAL] = 1'b1;
        end
      end
      default: d.cmd[CMD_ILLEGAL] = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rf_2r1w.sv
// 32x32 register file: two asynchronous read ports with write-through from
// the single synchronous write port; x0 is hardwired to zero.
module rf_2r1w
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_adr,
  input  logic [4:0]      rs2_adr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_adr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            wr_en
);

  logic [XLEN-1:0] mem_r [NREG];

  // Write port; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en && (rd_adr != 5'd0)) begin
      mem_r[rd_adr] <= rd_data;
    end
  end

  // Read port 1 with same-cycle forwarding of the write data.
  always_comb begin
    rs1_data = mem_r[rs1_adr];
    if (rs1_adr == 5'd0) begin
      rs1_data = '0;
    end else if (wr_en && (rd_adr == rs1_adr)) begin
      rs1_data = rd_data;
    end else begin
      rs1_data = mem_r[rs1_adr];
    end
  end

  // Read port 2 with same-cycle forwarding of the write data.
  always_comb begin
    rs2_data = mem_r[rs2_adr];
    if (rs2_adr == 5'd0) begin
      rs2_data = '0;
    end else if (wr_en && (rd_adr == rs2_adr)) begin
      rs2_data = rd_data;
    end else begin
      rs2_data = mem_r[rs2_adr];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: class decode, immediate generation, register read,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter logic [29:0] RESET_PC = 30'd0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_id,
  input  logic [29:0] pc_id,
  input  logic        stall,
  input  logic        rst_pipe,
  input  logic        flush_id,
  input  logic [4:0]  rd_adr_wb,
  input  logic [31:0] rd_data_wb,
  input  logic        wbk_en_wb,
  output logic        stall_ld,
  output logic [29:0] pc_ex,
  output logic [31:0] inst_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rd_adr_ex,
  output logic [2:0]  funct3_ex,
  output logic        funct7b5_ex,
  output logic [11:0] cmd_ex,
  output logic        wbk_en_ex
);

  rv32i_pkg::dec_t  dec_s;
  rv32i_pkg::idex_t idex_r;
  rv32i_pkg::idex_t idex_nx_s;
  logic [4:0]       rs1_adr_s;
  logic [4:0]       rs2_adr_s;
  logic [4:0]       rd_adr_s;
  logic [31:0]      rs1_rd_s;
  logic [31:0]      rs2_rd_s;
  logic [31:0]      imm_s;
  logic             wbk_s;
  logic             stall_ld_s;

  assign rs1_adr_s = inst_id[19:15];
  assign rs2_adr_s = inst_id[24:20];
  assign rd_adr_s  = inst_id[11:7];
  assign dec_s     = rv32i_pkg::decode_class(inst_id);
  assign imm_s     = rv32i_pkg::gen_imm(dec_s.imm_sel, inst_id);
  assign wbk_s     = ((dec_s.cmd & rv32i_pkg::WBK_MASK) != 12'h000) && (rd_adr_s != 5'd0);

  rf_2r1w u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_adr  (rs1_adr_s),
    .rs2_adr  (rs2_adr_s),
    .rs1_data (rs1_rd_s),
    .rs2_data (rs2_rd_s),
    .rd_adr   (rd_adr_wb),
    .rd_data  (rd_data_wb),
    .wr_en    (wbk_en_wb)
  );

  // wbk_en_ex already implies rd_adr_ex != 0, so x0 never causes a stall.
  assign stall_ld_s = idex_r.cmd[rv32i_pkg::CMD_LD] & idex_r.wbk_en & ~flush_id &
                      ((dec_s.rs1_use & (idex_r.rd_adr == rs1_adr_s)) |
                       (dec_s.rs2_use & (idex_r.rd_adr == rs2_adr_s)));
  assign stall_ld   = stall_ld_s;

  // Next ID/EX contents: rst_pipe > stall > flush/load-use bubble > decode.
  always_comb begin
    idex_nx_s = idex_r;
    if (rst_pipe || (!stall && (flush_id || stall_ld_s))) begin
      idex_nx_s      = '0;
      idex_nx_s.pc   = pc_id;
      idex_nx_s.inst = NOP_INST;
    end else if (!stall) begin
      idex_nx_s.pc       = pc_id;
      idex_nx_s.inst     = inst_id;
      idex_nx_s.rs1_data = rs1_rd_s;
      idex_nx_s.rs2_data = rs2_rd_s;
      idex_nx_s.imm      = imm_s;
      idex_nx_s.rd_adr   = rd_adr_s;
      idex_nx_s.funct3   = inst_id[14:12];
      idex_nx_s.funct7b5 = inst_id[30];
      idex_nx_s.cmd      = dec_s.cmd;
      idex_nx_s.wbk_en   = wbk_s;
    end else begin
      idex_nx_s = idex_r;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_r      <= '0;
      idex_r.pc   <= RESET_PC;
      idex_r.inst <= NOP_INST;
    end else begin
      idex_r <= idex_nx_s;
    end
  end

  assign pc_ex       = idex_r.pc;
  assign inst_ex     = idex_r.inst;
  assign rs1_data_ex = idex_r.rs1_data;
  assign rs2_data_ex = idex_r.rs2_data;
  assign imm_ex      = idex_r.imm;
  assign rd_adr_ex   = idex_r.rd_adr;
  assign funct3_ex   = idex_r.funct3;
  assign funct7b5_ex = idex_r.funct7b5;
  assign cmd_ex      = idex_r.cmd;
  assign wbk_en_ex   = idex_r.wbk_en;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference decoder and register model push
// the expected ID/EX contents each cycle; they are popped after the edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        stall, rst_pipe, flush_id;
  logic [4:0]  rd_adr_wb;
  logic [31:0] rd_data_wb;
  logic        wbk_en_wb;
  logic        stall_ld;
  logic [29:0] pc_ex;
  logic [31:0] inst_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rd_adr_ex;
  logic [2:0]  funct3_ex;
  logic        funct7b5_ex;
  logic [11:0] cmd_ex;
  logic        wbk_en_ex;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id), .stall(stall),
    .rst_pipe(rst_pipe), .flush_id(flush_id), .rd_adr_wb(rd_adr_wb),
    .rd_data_wb(rd_data_wb), .wbk_en_wb(wbk_en_wb), .stall_ld(stall_ld),
    .pc_ex(pc_ex), .inst_ex(inst_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rd_adr_ex(rd_adr_ex),
    .funct3_ex(funct3_ex), .funct7b5_ex(funct7b5_ex), .cmd_ex(cmd_ex),
    .wbk_en_ex(wbk_en_ex)
  );

  typedef struct {
    logic [29:0] pc;
    logic [31:0] inst, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] cmd;
    logic        wbk, bub, ok1, ok2;
  } exp_t;

  typedef struct {
    logic [11:0] cmd;
    logic [31:0] imm;
    logic        u1, u2, wb;
  } dec_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] mrf [32];
  logic        known [32];
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    d.cmd = 12'h000; d.imm = 32'h0; d.u1 = 1'b0; d.u2 = 1'b0; d.wb = 1'b0;
    case (i[6:0])
      7'h37: begin d.cmd = 12'h800; d.imm = {i[31:12], 12'h000}; d.wb = 1'b1; end
      7'h17: begin d.cmd = 12'h400; d.imm = {i[31:12], 12'h000}; d.wb = 1'b1; end
      7'h6F: begin d.cmd = 12'h200; d.wb = 1'b1;
                   d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h67: begin d.cmd = 12'h100; d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1'b1; d.wb = 1'b1; end
      7'h63: begin d.cmd = 12'h080; d.u1 = 1'b1; d.u2 = 1'b1;
                   d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
      7'h03: begin d.cmd = 12'h040; d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1'b1; d.wb = 1'b1; end
      7'h23: begin d.cmd = 12'h020; d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
                   d.u1 = 1'b1; d.u2 = 1'b1; end
      7'h13: begin d.cmd = 12'h010; d.imm = {{20{i[31]}}, i[31:20]}; d.u1 = 1'b1; d.wb = 1'b1; end
      7'h33: begin d.cmd = 12'h008; d.u1 = 1'b1; d.u2 = 1'b1; d.wb = 1'b1; end
      7'h73: d.cmd = (i == 32'h0000_0073) ? 12'h004 : (i == 32'h3020_0073) ? 12'h002 : 12'h001;
      default: d.cmd = 12'h001;
    endcase
    if (i[11:7] == 5'd0) d.wb = 1'b0;
    return d;
  endfunction

  function automatic logic [31:0] rf_rd(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    else if (we && wa == a) return wd;
    else return mrf[a];
  endfunction

  task automatic compare(input exp_t e);
    check("pc_ex", {2'b00, pc_ex}, {2'b00, e.pc});
    check("inst_ex", inst_ex, e.inst);
    check("cmd_ex", {20'd0, cmd_ex}, {20'd0, e.cmd});
    check("wbk_en_ex", {31'd0, wbk_en_ex}, {31'd0, e.wbk});
    check("rd_adr_ex", {27'd0, rd_adr_ex}, {27'd0, e.rd});
    if (!e.bub) begin
      check("imm_ex", imm_ex, e.imm);
      check("funct3_ex", {29'd0, funct3_ex}, {29'd0, e.f3});
      check("funct7b5_ex", {31'd0, funct7b5_ex}, {31'd0, e.f7});
      if (e.ok1) check("rs1_data_ex", rs1_data_ex, e.rs1);
      if (e.ok2) check("rs2_data_ex", rs2_data_ex, e.rs2);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [29:0] pc, input logic stl, fl, rp,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, output logic sl);
    dec_t d;
    exp_t nx;
    logic sm;
    logic [4:0] r1, r2;
    @(negedge clk);
    inst_id = ins; pc_id = pc; stall = stl; flush_id = fl; rst_pipe = rp;
    wbk_en_wb = we; rd_adr_wb = wa; rd_data_wb = wd;
    #1;
    d  = ref_dec(ins);
    r1 = ins[19:15];
    r2 = ins[24:20];
    sm = cur.cmd[6] && cur.wbk && !fl && ((d.u1 && cur.rd == r1) || (d.u2 && cur.rd == r2));
    sl = stall_ld;
    check("stall_ld", {31'd0, stall_ld}, {31'd0, sm});
    nx = cur;
    if (rp || (!stl && (fl || sm))) begin
      nx.pc = pc; nx.inst = 32'h0000_0013; nx.cmd = 12'h000; nx.wbk = 1'b0; nx.rd = 5'd0; nx.bub = 1'b1;
    end else if (!stl) begin
      nx.pc = pc; nx.inst = ins; nx.rd = ins[11:7]; nx.f3 = ins[14:12]; nx.f7 = ins[30];
      nx.cmd = d.cmd; nx.imm = d.imm; nx.wbk = d.wb; nx.bub = 1'b0;
      nx.rs1 = rf_rd(r1, we, wa, wd);
      nx.rs2 = rf_rd(r2, we, wa, wd);
      nx.ok1 = (r1 == 5'd0) || (we && wa == r1) || known[r1];
      nx.ok2 = (r2 == 5'd0) || (we && wa == r2) || known[r2];
    end
    exp_q.push_back(nx);
    cur = nx;
    if (we && wa != 5'd0) begin
      mrf[wa] = wd;
      known[wa] = 1'b1;
    end
    @(posedge clk);
    #1;
    compare(exp_q.pop_front());
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_pc"}, {2'b00, pc_ex}, 32'h0);
    check({tag, "_inst"}, inst_ex, 32'h0000_0013);
    check({tag, "_rs1"}, rs1_data_ex, 32'h0);
    check({tag, "_rs2"}, rs2_data_ex, 32'h0);
    check({tag, "_imm"}, imm_ex, 32'h0);
    check({tag, "_misc"}, {17'd0, rd_adr_ex, funct3_ex, funct7b5_ex, wbk_en_ex, stall_ld}, 32'h0);
    check({tag, "_cmd"}, {20'd0, cmd_ex}, 32'h0);
  endtask

  task automatic model_reset();
    cur.pc = 30'd0; cur.inst = 32'h0000_0013; cur.rs1 = 32'h0; cur.rs2 = 32'h0; cur.imm = 32'h0;
    cur.rd = 5'd0; cur.f3 = 3'd0; cur.f7 = 1'b0; cur.cmd = 12'h000; cur.wbk = 1'b0;
    cur.bub = 1'b0; cur.ok1 = 1'b1; cur.ok2 = 1'b1;
    for (int i = 0; i < 32; i++) known[i] = (i == 0);
  endtask

  task automatic init_rf();
    logic s;
    for (int r = 1; r < 32; r++) begin
      step(32'h0000_0013, 30'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'(r), 32'h1000_0000 + 32'(r) * 32'h0001_0101, s);
    end
  endtask

  initial begin
    logic s;
    logic [31:0] r;
    logic [6:0] optab [9];
    rst_n = 1'b0; inst_id = 32'h0000_0013; pc_id = 30'd0; stall = 1'b0; rst_pipe = 1'b0;
    flush_id = 1'b0; rd_adr_wb = 5'd0; rd_data_wb = 32'h0; wbk_en_wb = 1'b0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_check("por");
    @(negedge clk);
    rst_n = 1'b1;
    init_rf();
    step(32'h0031_8233, 30'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h0051_2423, 30'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    wbk_en_wb = 1'b0;
    #2 rst_n = 1'b0;
    #1 reset_check("mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(32'h0050_0093, 30'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("addi_imm", imm_ex, 32'd5);
    check("addi_rd", {27'd0, rd_adr_ex}, 32'd1);
    check("addi_wbk", {31'd0, wbk_en_ex}, 32'd1);
    check("addi_cmd", {20'd0, cmd_ex}, 32'h010);
    init_rf();

    // Immediate formats.
    step(32'hFE00_0EE3, 30'h40, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("beq_imm", imm_ex, 32'hFFFF_FFFC);
    check("beq_pc", {2'b00, pc_ex}, 32'h40);
    step(32'h801F_F0EF, 30'h41, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("jal_imm", imm_ex, 32'hFFFF_F800);
    step(32'hABCD_E2B7, 30'h42, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("lui_imm", imm_ex, 32'hABCD_E000);
    step(32'h0042_80E7, 30'h43, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h0000_1517, 30'h44, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h4020_84B3, 30'h45, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);

    // Write-through and x0.
    step(32'h0031_8233, 30'h50, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, s);
    check("wt_rs1", rs1_data_ex, 32'hDEAD_BEEF);
    check("wt_rs2", rs2_data_ex, 32'hDEAD_BEEF);
    step(32'h0000_0013, 30'h51, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678, s);
    step(32'h0000_0433, 30'h52, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("x0_rs1", rs1_data_ex, 32'h0);
    check("x0_rs2", rs2_data_ex, 32'h0);

    // Load-use: one bubble, then the dependent add issues.
    step(32'h0001_2303, 30'h60, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h0013_03B3, 30'h61, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("lu_stall", {31'd0, s}, 32'd1);
    check("lu_bubble_cmd", {20'd0, cmd_ex}, 32'h0);
    check("lu_bubble_inst", inst_ex, 32'h0000_0013);
    step(32'h0013_03B3, 30'h61, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("lu_release", {31'd0, s}, 32'd0);
    check("lu_issue_cmd", {20'd0, cmd_ex}, 32'h008);
    check("lu_issue_rd", {27'd0, rd_adr_ex}, 32'd7);
    step(32'h0001_2003, 30'h62, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h0010_03B3, 30'h63, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("lu_x0_nostall", {31'd0, s}, 32'd0);
    check("lu_x0_cmd", {20'd0, cmd_ex}, 32'h008);

    // Flush, stall and rst_pipe priority.
    step(32'h0050_0093, 30'h70, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("flush_cmd", {20'd0, cmd_ex}, 32'h0);
    check("flush_inst", inst_ex, 32'h0000_0013);
    step(32'hABCD_E2B7, 30'h71, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h0050_0093, 30'h72, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("stall_hold_inst", inst_ex, 32'hABCD_E2B7);
    check("stall_hold_pc", {2'b00, pc_ex}, 32'h71);
    step(32'h0050_0093, 30'h73, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, s);
    check("rstpipe_cmd", {20'd0, cmd_ex}, 32'h0);
    check("rstpipe_inst", inst_ex, 32'h0000_0013);

    // Illegal, mret, ecall.
    step(32'hFFFF_FFFF, 30'h80, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("ill_cmd", {20'd0, cmd_ex}, 32'h001);
    check("ill_wbk", {31'd0, wbk_en_ex}, 32'd0);
    step(32'h3020_0073, 30'h81, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("mret_cmd", {20'd0, cmd_ex}, 32'h002);
    step(32'h0000_0073, 30'h82, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, s);
    check("ecall_cmd", {20'd0, cmd_ex}, 32'h004);

    // Random mix of legal classes and control inputs.
    optab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    for (int k = 0; k < 80; k++) begin
      r = $urandom();
      step({r[31:7], optab[$urandom_range(0, 8)]}, 30'($urandom()),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(), s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage directly downstream of instruction fetch. It consumes inst_id/pc_id, decodes RV32I opcodes and generates immediates. It reads the 32x32 register file, with write-through from the writeback port, and registers everything into the ID/EX pipeline register. It also detects load-use hazards and raises stall_ld back to fetch.

Parameters:
RESET_PC, 30'd0, pc_ex value after reset.
NOP_INST, 32'h0000_0013, instruction injected as a bubble (addi x0,x0,0), reported on inst_ex.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
inst_id  in  32  instruction from fetch
pc_id  in  30  [31:2] PC of inst_id
stall  in  1  global pipeline hold
rst_pipe  in  1  synchronous pipeline flush
flush_id  in  1  ID instruction is wrong-path (jump/ecall/interrupt/exception/post-jump)
rd_adr_wb  in  5  writeback register index
rd_data_wb  in  32  writeback data
wbk_en_wb  in  1  writeback enable
stall_ld  out  1  load-use hazard, combinational
pc_ex  out  30  registered PC
inst_ex  out  32  registered instruction (NOP_INST on bubble)
rs1_data_ex  out  32  registered rs1 value
rs2_data_ex  out  32  registered rs2 value
imm_ex  out  32  registered sign-extended immediate
rd_adr_ex  out  5  registered destination index
funct3_ex  out  3  registered funct3
funct7b5_ex  out  1  registered inst[30]
cmd_ex  out  12  one-hot class {lui,auipc,jal,jalr,br,ld,st,alui,alu,ecall,mret,illegal}
wbk_en_ex  out  1  registered writeback enable (0 when rd==0)

Behaviour:
- Reset (async): all *_ex outputs 0 except pc_ex=RESET_PC and inst_ex=NOP_INST. cmd_ex=0 and wbk_en_ex=0 form the bubble encoding. stall_ld=0.
- Decode is combinational on inst_id; opcode[6:0] selects the class.
  - Unknown opcode, or SYSTEM with funct3!=0 and not mret: cmd illegal=1, wbk_en=0.
  - ecall = 32'h0000_0073; mret = 32'h3020_0073.
- Immediates:
  - I = sext(inst[31:20])
  - S = sext({inst[31:25], inst[11:7]})
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U = {inst[31:12], 12'b0}
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - imm=0 for R-type.
- rs1 is used by jalr, br, ld, st, alui, alu. rs2 is used by br, st, alu.
- wbk_en = class in {lui, auipc, jal, jalr, ld, alui, alu} and rd!=0.
- Register file: 2 async read ports, 1 sync write port on clk.
  - x0 reads 0 and writes to it are ignored.
  - Write-through: if wbk_en_wb and rd_adr_wb==rsN!=0, the read returns rd_data_wb in the same cycle.
- stall_ld = cmd_ex.ld & wbk_en_ex & ~flush_id, and either:
  - rd_adr_ex==rs1 with rs1 used, or
  - rd_adr_ex==rs2 with rs2 used.
- ID/EX register update priority per cycle:
  1. rst_pipe: load bubble.
  2. stall: hold all.
  3. flush_id: load bubble.
  4. stall_ld: load bubble. Fetch holds pc/inst, so the same ID instruction is re-decoded next cycle.
  5. Otherwise: load the decoded values.
- Bubble = cmd_ex 0, wbk_en_ex 0, rd_adr_ex 0, inst_ex NOP_INST. pc_ex takes pc_id except under stall.
- Latency: 1 cycle ID→EX. A load followed immediately by a dependent instruction costs exactly 1 bubble.
- A regfile write occurs even while stall or stall_ld is asserted; WB ownership lies outside this block.
- stall_ld is never asserted for rd==0.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111, OP_BR 1100011, OP_LD 0000011, OP_ST 0100011, OP_ALUI 0010011, OP_ALU 0110011, OP_SYS 1110011
  - cmd_ex bit-index constants
  - NOP_INST
- One sub-module: rf_2r1w (32x32 register file with write-through and x0 hardwiring).

Test Plan:
- Reset with rst_n low mid-run → all *_ex 0, inst_ex=32'h13, stall_ld=0. After release, first decode of addi x1,x0,5 gives imm_ex=5, rd_adr_ex=1, wbk_en_ex=1, cmd alui.
- Immediates: beq pc=0x100 with inst 32'hFE000EE3 → imm_ex=32'hFFFFFFFC. jal x1,-2048 → imm_ex=32'hFFFFF800. lui x5,0xABCDE → imm_ex=32'hABCDE000.
- Write-through: wbk_en_wb=1, rd_adr_wb=3, rd_data_wb=32'hDEADBEEF in the same cycle as decode of add x4,x3,x3 → rs1_data_ex=rs2_data_ex=32'hDEADBEEF. A write to x0 followed by a read of x0 → 0.
- Load-use: lw x6,0(x2) then add x7,x6,x1 → stall_ld=1 for exactly 1 cycle, one bubble in EX, then add issues. Same pair with rd=x0 → no stall.
- Flush versus stall: flush_id=1 with stall=0 → bubble. stall=1 with flush_id=1 → EX regs hold their prior values. rst_pipe together with stall → bubble.
- Illegal: inst 32'hFFFFFFFF → cmd illegal=1, wbk_en_ex=0. mret 32'h30200073 → cmd mret=1.
